// File: rtl/calc_sequencer.sv
// calc_sequencer: hex keypad calculator sequencer (operand entry, op select, compute, result).
// Build option CALC_SEQ_MULT_EN adds key 0x12 as a 16-cycle shift-add multiply; otherwise 0x12 is ignored.
module calc_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  keycode,
    input  logic        newkey,
    output logic [15:0] value,
    output logic        busy,
    output logic        ovf,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        OP_WAIT = 3'd1,
        ENTRY_B = 3'd2,
        COMPUTE = 3'd3,
        RESULT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d, pend_op_q, pend_op_d, key_op;
    logic        pend_v_q, pend_v_d;
    logic [15:0] a_q, a_d, b_q, b_d, value_q, value_d;
    logic        busy_q, busy_d, ovf_q, ovf_d;
    logic        is_digit, is_op, is_eq, is_clr, done;
    logic [3:0]  digit;
    logic [16:0] addsub;
    logic [15:0] result;
    logic        res_ovf;

    // newkey is a one-cycle valid with no ready: a key arriving while COMPUTE is active is dropped.
    always_comb begin
        digit    = keycode[3:0];
        is_digit = newkey && (keycode[4] == 1'b0);
        is_eq    = newkey && (keycode == 5'h13);
        is_clr   = newkey && (keycode == 5'h14);
        is_op    = 1'b0;
        key_op   = OP_ADD;
        if (newkey) begin
            case (keycode)
                5'h10: is_op = 1'b1;
                5'h11: begin
                    is_op  = 1'b1;
                    key_op = OP_SUB;
                end
`ifdef CALC_SEQ_MULT_EN
                5'h12: begin
                    is_op  = 1'b1;
                    key_op = OP_MUL;
                end
`endif
                default: ;
            endcase
        end
    end

    // Bit 16 is the carry for add and the borrow (A < B) for subtract.
    always_comb begin
        if (op_q == OP_SUB) addsub = {1'b0, a_q} - {1'b0, b_q};
        else                addsub = {1'b0, a_q} + {1'b0, b_q};
    end

`ifdef CALC_SEQ_MULT_EN
    logic [31:0] prod_q, prod_d, prod_step;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    logic [16:0] mul_sum;

    // prod holds {partial high half, remaining multiplier bits}; A is added then the pair shifts right.
    always_comb begin
        mul_sum   = {1'b0, prod_q[31:16]} + (prod_q[0] ? {1'b0, a_q} : 17'h0_0000);
        prod_step = {mul_sum, prod_q[15:1]};
    end
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pend_op_d = pend_op_q;
        pend_v_d  = pend_v_q;
        a_d       = a_q;
        b_d       = b_q;
        value_d   = value_q;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        done      = 1'b0;
        result    = addsub[15:0];
        res_ovf   = addsub[16];
`ifdef CALC_SEQ_MULT_EN
        prod_d    = prod_q;
        mul_cnt_d = mul_cnt_q;
`endif
        if (state_q == COMPUTE) begin
`ifdef CALC_SEQ_MULT_EN
            if (op_q == OP_MUL) begin
                prod_d    = prod_step;
                mul_cnt_d = mul_cnt_q + 4'd1;
                done      = (mul_cnt_q == 4'd15);
                result    = prod_step[15:0];
                res_ovf   = |prod_step[31:16];
            end else begin
                done = 1'b1;
            end
`else
            done = 1'b1;
`endif
            if (done) begin
                a_d     = result;
                value_d = result;
                ovf_d   = res_ovf;
                busy_d  = 1'b0;
                if (pend_v_q) begin
                    op_d     = pend_op_q;
                    pend_v_d = 1'b0;
                    state_d  = OP_WAIT;
                end else begin
                    state_d  = RESULT;
                end
            end
        end else if (is_clr) begin
            state_d   = ENTRY_A;
            a_d       = 16'h0000;
            b_d       = 16'h0000;
            op_d      = OP_ADD;
            pend_op_d = OP_ADD;
            pend_v_d  = 1'b0;
            ovf_d     = 1'b0;
            value_d   = 16'h0000;
        end else begin
            case (state_q)
                ENTRY_A: begin
                    if (is_digit) begin
                        a_d     = {a_q[11:0], digit};
                        value_d = {a_q[11:0], digit};
                    end else if (is_op) begin
                        op_d    = key_op;
                        state_d = OP_WAIT;
                    end
                end
                OP_WAIT: begin
                    if (is_digit) begin
                        b_d     = {12'h000, digit};
                        value_d = {12'h000, digit};
                        state_d = ENTRY_B;
                    end else if (is_op) begin
                        op_d = key_op;
                    end
                end
                ENTRY_B: begin
                    if (is_digit) begin
                        b_d     = {b_q[11:0], digit};
                        value_d = {b_q[11:0], digit};
                    end else if (is_eq || is_op) begin
                        state_d = COMPUTE;
                        busy_d  = 1'b1;
                        if (is_op) begin
                            pend_op_d = key_op;
                            pend_v_d  = 1'b1;
                        end
`ifdef CALC_SEQ_MULT_EN
                        prod_d    = {16'h0000, b_q};
                        mul_cnt_d = 4'd0;
`endif
                    end
                end
                RESULT: begin
                    if (is_digit) begin
                        a_d     = {12'h000, digit};
                        value_d = {12'h000, digit};
                        ovf_d   = 1'b0;
                        state_d = ENTRY_A;
                    end else if (is_op) begin
                        op_d    = key_op;
                        state_d = OP_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ENTRY_A;
            op_q      <= OP_ADD;
            pend_op_q <= OP_ADD;
            pend_v_q  <= 1'b0;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            value_q   <= 16'h0000;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef CALC_SEQ_MULT_EN
            prod_q    <= 32'h0000_0000;
            mul_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pend_op_q <= pend_op_d;
            pend_v_q  <= pend_v_d;
            a_q       <= a_d;
            b_q       <= b_d;
            value_q   <= value_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
`ifdef CALC_SEQ_MULT_EN
            prod_q    <= prod_d;
            mul_cnt_q <= mul_cnt_d;
`endif
        end
    end

    assign value     = value_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: a key-level calculator model predicts value/busy/ovf every cycle.
// Directed sequences pin the model with literal results, then randomized key traffic runs against it.
`timescale 1ns/1ps
module tb_calc_sequencer;
`ifdef CALC_SEQ_MULT_EN
    localparam bit MULT = 1'b1;
`else
    localparam bit MULT = 1'b0;
`endif
    localparam int M_EA = 0, M_OW = 1, M_EB = 2, M_CMP = 3, M_RES = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        newkey = 1'b0;
    logic [4:0]  keycode = 5'h00;
    logic [15:0] value;
    logic        busy, ovf;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic [17:0] exp_q[$];

    calc_sequencer dut (
        .clock(clock), .reset(reset), .keycode(keycode), .newkey(newkey),
        .value(value), .busy(busy), .ovf(ovf), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #100 clock = ~clock;

    // ---------------- reference model ----------------
    int unsigned m_a, m_b, m_val, m_res;
    bit          m_ovf, m_busy, m_rov, m_pv;
    int          m_mode, m_op, m_pend, m_left;

    always @(posedge clock) begin : model
        int     k;
        bit     k_op;
        longint p;
        if (reset) begin
            m_a = 0; m_b = 0; m_val = 0; m_ovf = 0; m_busy = 0;
            m_op = 16; m_pv = 0; m_pend = 16; m_mode = M_EA; m_left = 0;
        end else if (m_mode == M_CMP) begin
            m_left--;
            if (m_left == 0) begin
                m_a = m_res; m_val = m_res; m_ovf = m_rov; m_busy = 0;
                if (m_pv) begin m_op = m_pend; m_pv = 0; m_mode = M_OW; end
                else m_mode = M_RES;
            end
        end else if (newkey) begin
            k    = int'(keycode);
            k_op = (k == 16) || (k == 17) || (MULT && k == 18);
            if (k == 20) begin
                m_a = 0; m_b = 0; m_op = 16; m_pv = 0; m_ovf = 0; m_mode = M_EA;
            end else begin
                case (m_mode)
                    M_EA: if (k < 16) m_a = (m_a * 16 + k) % 65536;
                          else if (k_op) begin m_op = k; m_mode = M_OW; end
                    M_OW: if (k < 16) begin m_b = k; m_mode = M_EB; end
                          else if (k_op) m_op = k;
                    M_EB: if (k < 16) m_b = (m_b * 16 + k) % 65536;
                          else if (k == 19 || k_op) begin
                              if (k_op) begin m_pend = k; m_pv = 1; end
                              m_mode = M_CMP; m_busy = 1;
                              if (m_op == 16) begin
                                  m_res = (m_a + m_b) % 65536; m_rov = (m_a + m_b) > 65535; m_left = 1;
                              end else if (m_op == 17) begin
                                  m_res = (m_a + 65536 - m_b) % 65536; m_rov = m_a < m_b; m_left = 1;
                              end else begin
                                  p = longint'(m_a) * longint'(m_b);
                                  m_res = int'(p % 65536); m_rov = (p / 65536) != 0; m_left = 16;
                              end
                          end
                    M_RES: if (k < 16) begin m_a = k; m_ovf = 0; m_mode = M_EA; end
                           else if (k_op) begin m_op = k; m_mode = M_OW; end
                    default: ;
                endcase
            end
            if (m_mode == M_EB) m_val = m_b;
            else if (m_mode != M_CMP) m_val = m_a;
        end
        if (chk_en) exp_q.push_back({m_busy, m_ovf, m_val[15:0]});
    end

    // ---------------- scoreboard: one compare per cycle ----------------
    always @(negedge clock) begin : compare
        logic [17:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({busy, ovf, value} !== e) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t state=%0d busy/ovf/value got %b/%b/%h expected %b/%b/%h",
                         $time, dbg_state, busy, ovf, value, e[17], e[16], e[15:0]);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic press(input logic [4:0] k);
        newkey  = 1'b1;
        keycode = k;
        @(negedge clock);
        newkey  = 1'b0;
        keycode = 5'($urandom_range(0, 31));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [4:0] pick_key();
        int r;
        r = $urandom_range(0, 99);
        if (r < 45)      return 5'($urandom_range(0, 15));
        else if (r < 80) return 5'($urandom_range(16, 19));
        else if (r < 85) return 5'h14;
        else             return 5'($urandom_range(21, 31));
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim
        int busy_cnt;
        @(negedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_lit("reset_value", 32'(value), 32'h0000);
        check_lit("reset_busy", 32'(busy), 32'h0);
        check_lit("reset_ovf", 32'(ovf), 32'h0);

        // five digits: the first nibble falls off the top
        press(5'h01); press(5'h02); press(5'h03); press(5'h04); press(5'h05);
        check_lit("digits_value", 32'(value), 32'h2345);
        check_lit("digits_model", m_val, 32'h2345);
        check_lit("digits_busy", 32'(busy), 32'h0);

        press(5'h14);
        press(5'h01); press(5'h02); press(5'h10); press(5'h03); press(5'h04); press(5'h13);
        check_lit("add_busy", 32'(busy), 32'h1);
        idle(1);
        check_lit("add_value", 32'(value), 32'h0046);
        check_lit("add_model", m_val, 32'h0046);
        check_lit("add_ovf", 32'(ovf), 32'h0);

        press(5'h14);
        press(5'h0F); press(5'h0F); press(5'h0F); press(5'h0F); press(5'h10); press(5'h01); press(5'h13);
        idle(1);
        check_lit("carry_value", 32'(value), 32'h0000);
        check_lit("carry_ovf", 32'(ovf), 32'h1);
        press(5'h07);
        check_lit("after_result_value", 32'(value), 32'h0007);
        check_lit("after_result_ovf", 32'(ovf), 32'h0);

        press(5'h14);
        press(5'h05); press(5'h11); press(5'h02); press(5'h10);
        idle(1);
        check_lit("chain_first", 32'(value), 32'h0003);
        press(5'h01); press(5'h13);
        idle(1);
        check_lit("chain_final", 32'(value), 32'h0004);
        check_lit("chain_model", m_val, 32'h0004);

        press(5'h14);
        if (MULT) begin
            press(5'h01); press(5'h00); press(5'h00); press(5'h12);
            press(5'h02); press(5'h00); press(5'h00); press(5'h13);
            busy_cnt = 0;
            for (int i = 0; i < 40 && busy; i++) begin
                busy_cnt++;
                newkey  = (i == 3);
                keycode = 5'h14;
                @(negedge clock);
            end
            newkey = 1'b0;
            check_lit("mul_busy_cycles", busy_cnt, 32'd16);
            check_lit("mul_value", 32'(value), 32'h0000);
            check_lit("mul_ovf", 32'(ovf), 32'h1);
            press(5'h14);
            press(5'h01); press(5'h00); press(5'h00); press(5'h12);
            press(5'h02); press(5'h00); press(5'h00); press(5'h13);
            idle(6);
        end else begin
            press(5'h03); press(5'h12); press(5'h04);
            check_lit("mul_key_ignored", 32'(value), 32'h0034);
            press(5'h10); press(5'h02); press(5'h13);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_lit("abort_value", 32'(value), 32'h0000);
        check_lit("abort_busy", 32'(busy), 32'h0);
        press(5'h09);
        check_lit("abort_digit", 32'(value), 32'h0009);

        // randomized key traffic, keycode toggling freely while newkey is low
        repeat (4000) begin
            reset   = ($urandom_range(0, 599) == 0);
            newkey  = ($urandom_range(0, 2) == 0);
            keycode = pick_key();
            @(negedge clock);
        end
        reset  = 1'b0;
        newkey = 1'b0;
        idle(20);
        chk_en = 1'b0;
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
